// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares a single memory command port between an instruction-fetch requester
// and a load/store requester.
//
// The data side normally wins arbitration. A starvation counter guarantees
// that a waiting fetch gets the port after STARVE_MAX consecutive data grants.
// A fetch can be killed (branch redirect) while pending or in flight. A killed
// in-flight fetch still runs to mem_done, but no if_ack is produced for it.
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   if_req/if_addr/if_kill             fetch request side
//   if_ack/if_rdata                    fetch completion (one-cycle pulse)
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata load/store request side
//   dm_ack/dm_rdata                    load/store completion (one-cycle pulse)
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata   registered shared command
//   mem_done/mem_rdata                 memory completion and read data
//   stall_if/stall_mem                 stall indications to the hazard unit
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            if_kill,
    output logic            if_ack,
    output logic [DW-1:0]   if_rdata,
    input  logic            dm_req,
    input  logic            dm_we,
    input  logic [DW/8-1:0] dm_be,
    input  logic [AW-1:0]   dm_addr,
    input  logic [DW-1:0]   dm_wdata,
    output logic            dm_ack,
    output logic [DW-1:0]   dm_rdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_done,
    input  logic [DW-1:0]   mem_rdata,
    output logic            stall_if,
    output logic            stall_mem
);

    localparam int BW = DW / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [BW-1:0]   r_mem_be;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;
    logic [3:0]      r_starve_cnt;
    logic            r_killed;

    logic            w_idle;
    logic            w_if_busy;
    logic            w_dm_busy;
    logic            w_starved;
    logic            w_grant_if;
    logic            w_grant_dm;
    logic            w_if_dead;

    assign w_idle    = (r_state == IDLE);
    assign w_if_busy = (r_state == IF_BUSY);
    assign w_dm_busy = (r_state == DM_BUSY);
    assign w_starved = (r_starve_cnt == 4'(STARVE_MAX));

    // Data side has priority unless the fetch has waited STARVE_MAX grants.
    // A fetch being killed this cycle is never granted; the data side then
    // takes the port even when the counter is saturated.
    assign w_grant_if = w_idle & if_req & ~if_kill & (~dm_req | w_starved);
    assign w_grant_dm = w_idle & dm_req & ~w_grant_if;

    // A kill arriving in the very cycle of mem_done must also suppress the ack,
    // so the live if_kill is folded in alongside the registered flag.
    assign w_if_dead = r_killed | if_kill;

    assign if_ack   = w_if_busy & mem_done & ~w_if_dead;
    assign if_rdata = if_ack ? mem_rdata : '0;
    assign dm_ack   = w_dm_busy & mem_done;
    assign dm_rdata = (dm_ack & ~r_mem_we) ? mem_rdata : '0;

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dm_req & ~dm_ack;

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_starve_cnt <= '0;
            r_killed     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_killed <= 1'b0;
                    if (w_grant_if) begin
                        r_state     <= IF_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= '0;
                        r_mem_addr  <= if_addr;
                        r_mem_wdata <= '0;
                    end else if (w_grant_dm) begin
                        r_state     <= DM_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= dm_we;
                        r_mem_be    <= dm_be;
                        r_mem_addr  <= dm_addr;
                        r_mem_wdata <= dm_wdata;
                    end
                end
                IF_BUSY: begin
                    if (if_kill) begin
                        r_killed <= 1'b1;
                    end
                    if (mem_done) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        r_killed  <= 1'b0;
                    end
                end
                DM_BUSY: begin
                    if (mem_done) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_mem_req <= 1'b0;
                    r_killed  <= 1'b0;
                end
            endcase

            // Starvation counter counts data grants that overtook a live fetch.
            if (!if_req || w_grant_if) begin
                r_starve_cnt <= '0;
            end else if (w_grant_dm && !if_kill && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

endmodule
